// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Bundles the push/pop strobes, control inputs and status outputs of the
//   UART receive buffer. The clock and reset are not part of the bundle.
//
//   Handshake: WrEn is a one-cycle push strobe from the UART receiver, and
//   WrData is sampled with it. There is no ready back to the receiver. A push
//   into a full buffer with no pop in the same cycle is dropped and sets
//   Overrun. RdEn pops the head entry when Empty=0, and is ignored when
//   Empty=1. RdData is valid whenever Empty=0 (first-word-fall-through).
//
//   Modports:
//     master : the side that drives the strobes and controls (host or bench)
//     slave  : the buffer itself
interface uart_rx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int DEPTH_LOG2 = 4
);
   logic                  WrEn;
   logic [DATA_BITS-1:0]  WrData;
   logic                  RdEn;
   logic [DATA_BITS-1:0]  RdData;
   logic                  Flush;
   logic                  OverrunClr;
   logic [DEPTH_LOG2:0]   Threshold;
   logic                  Empty;
   logic                  Full;
   logic [DEPTH_LOG2:0]   Count;
   logic                  AboveThreshold;
   logic                  Overrun;

   modport master (
      output WrEn, WrData, RdEn, Flush, OverrunClr, Threshold,
      input  RdData, Empty, Full, Count, AboveThreshold, Overrun
   );

   modport slave (
      input  WrEn, WrData, RdEn, Flush, OverrunClr, Threshold,
      output RdData, Empty, Full, Count, AboveThreshold, Overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Circular byte buffer that sits directly downstream of the UART receiver.
//   The read side is first-word-fall-through. The buffer reports occupancy,
//   a programmable threshold flag and a sticky overrun flag.
//
//   Ports:
//     Clock   : system clock; all state changes on the rising edge
//     ResetN  : asynchronous, active-low reset
//     bus     : uart_rx_fifo_if.slave
//               (WrEn/WrData push, RdEn pop, RdData head byte, Flush,
//                OverrunClr, Threshold, Empty, Full, Count,
//                AboveThreshold, Overrun)
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic           Clock,
   input  logic           ResetN,
   uart_rx_fifo_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

   logic [DATA_BITS-1:0]  mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overrun_q, overrun_d;

   logic empty, full, pop, push, drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_COUNT);

   // A pop in the same cycle frees the slot, so a full buffer can still accept
   // a push when it is also being read.
   assign pop  = bus.RdEn & ~empty;
   assign push = bus.WrEn & (~full | pop);
   assign drop = bus.WrEn & ~push;

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      // Flush discards pointers and occupancy but leaves the array untouched.
      if (bus.Flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + DEPTH_LOG2'(1);
         if (pop)  rptr_d = rptr_q + DEPTH_LOG2'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
         endcase
      end

      // Overrun is independent of Flush. Setting it wins over clearing it.
      if (drop)                overrun_d = 1'b1;
      else if (bus.OverrunClr) overrun_d = 1'b0;
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // The storage array has no reset. Its contents are only meaningful behind
   // the pointers.
   always_ff @(posedge Clock) begin
      if (push && !bus.Flush) mem_q[wptr_q] <= bus.WrData;
   end

   assign bus.RdData         = mem_q[rptr_q];
   assign bus.Empty          = empty;
   assign bus.Full           = full;
   assign bus.Count          = count_q;
   assign bus.AboveThreshold = (count_q >= bus.Threshold);
   assign bus.Overrun        = overrun_q;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver flags as complete and holds it in a circular buffer until the host logic pops it. The read side is first-word-fall-through. It reports occupancy, a programmable threshold flag and a sticky overrun flag, so the consumer can service the UART in bursts without losing bytes.

## Interface
- DATA_BITS, 8: width of each stored byte; matches the receiver data width.
- DEPTH_LOG2, 4: log2 of the buffer depth; default depth is 16 entries.
- Clock  input  1  system clock (50 MHz); all state changes on the rising edge.
- ResetN  input  1  reset, asynchronous, active-low.
- WrEn  input  1  push strobe, driven by the receiver byte-ready pulse; one cycle wide per byte.
- WrData  input  DATA_BITS  byte to push; sampled when WrEn=1.
- RdEn  input  1  pop strobe from the consumer.
- RdData  output  DATA_BITS  head-of-buffer byte; valid whenever Empty=0.
- Flush  input  1  synchronous discard of all contents.
- OverrunClr  input  1  synchronous clear of Overrun.
- Threshold  input  DEPTH_LOG2+1  occupancy level for AboveThreshold.
- Empty  output  1  no entries stored.
- Full  output  1  2^DEPTH_LOG2 entries stored.
- Count  output  DEPTH_LOG2+1  current occupancy, 0 to 2^DEPTH_LOG2.
- AboveThreshold  output  1  Count >= Threshold.
- Overrun  output  1  sticky flag; set when a push was dropped.

## Operation
- Storage: 2^DEPTH_LOG2 x DATA_BITS register array.
- Pointers:
  - Write pointer and read pointer are DEPTH_LOG2 bits wide and wrap naturally from the last index to 0.
  - Count is a separate DEPTH_LOG2+1 bit register.
- Push accepted when WrEn=1 and (Full=0, or RdEn=1 with Empty=0):
  - Array[wptr] <= WrData.
  - wptr increments.
- Pop accepted when RdEn=1 and Empty=0:
  - rptr increments.
  - A pop with Empty=1 is ignored: no pointer or count change, no error flag.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Full with WrEn=1 and RdEn=1: both operations occur, Count stays at full, and Overrun is not set.
- Empty with WrEn=1 and RdEn=1: the push is accepted and the pop is ignored, so Count becomes 1.
- Full with WrEn=1 and RdEn=0: the byte is dropped, contents are unchanged, and Overrun <= 1.
- Overrun:
  - Held until OverrunClr=1.
  - Set has priority over clear in the same cycle.
  - Unaffected by Flush.
- Flush:
  - wptr, rptr and Count go to 0.
  - Overrides any push or pop in the same cycle.
  - Array contents are not cleared.
- Flag definitions:
  - Empty = (Count==0).
  - Full = (Count==2^DEPTH_LOG2).
  - AboveThreshold = (Count >= Threshold), unsigned compare; Threshold=0 forces it to 1.
- RdData = Array[rptr]; combinational from registered state, with no read latency.

## Timing
- Reset values: Count=0, Empty=1, Full=0, AboveThreshold=(Threshold==0), Overrun=0, wptr=rptr=0.
- RdData is undefined after reset until the first push; the array has no reset.
- Push on edge N:
  - Count, Empty and Full reflect it after edge N.
  - RdData presents the byte in cycle N+1 if the buffer was empty before the push.
- Pop on edge N: RdData shows the next entry after edge N.
- Throughput: one push and one pop per cycle, sustained.
- WrEn held high for k cycles means k pushes; the receiver guarantees single-cycle strobes.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously; the in-flight push is lost.

## Test plan
- Reset, then push 0xA5, 0x3C, 0x0F one per cycle:
  - Count goes 1, 2, 3 and Empty drops after the first edge.
  - RdData=0xA5.
  - Three pops read out 0xA5, 0x3C, 0x0F, then Empty=1 and Count=0.
- Push 16 bytes 0x00 to 0x0F, then push 0xFF:
  - Full=1 and Overrun=1; 0xFF is dropped.
  - Drain returns 0x00 to 0x0F in order.
  - OverrunClr then gives Overrun=0.
- Full buffer with simultaneous WrEn and RdEn (WrData=0x77):
  - Count stays 16 and Overrun stays 0.
  - The last popped byte is 0x77 after 15 earlier entries.
- Wrap-around: 40 interleaved push/pop cycles with random bytes; a scoreboard matches the order exactly and Count never exceeds 16.
- Threshold=4:
  - AboveThreshold=0 at Count=3 and 1 at Count=4.
  - Flush with simultaneous WrEn gives Count=0, Empty=1 and AboveThreshold=0.
- Assert ResetN=0 mid-stream with Count=7 and Overrun=1: outputs return to reset values without a clock edge.
